// File: rtl/keccak_padder_if.sv
// Block-state link between the message padder and the Keccak round logic.
// The word side feeds the padder; the block side is read by the permutation.
interface keccak_padder_if;
    logic [63:0]  in;
    logic         in_valid;
    logic         in_ready;
    logic         is_last;
    logic [2:0]   byte_num;
    logic [575:0] out;
    logic         out_valid;
    logic         out_last;
    logic         f_ack;

    modport master (
        output in, in_valid, is_last, byte_num, f_ack,
        input  in_ready, out, out_valid, out_last
    );

    modport slave (
        input  in, in_valid, is_last, byte_num, f_ack,
        output in_ready, out, out_valid, out_last
    );
endinterface

// File: rtl/keccak_padder.sv
// Keccak-512 pad10*1 padder: packs 64-bit words into 576-bit rate blocks.
// Define PADDER_SHA3_DOMAIN_EN to use the SHA-3 domain pad byte 0x06.
module keccak_padder #(
    parameter int W          = 64,
    parameter int RATE_WORDS = 9
) (
    input  logic            clk,
    input  logic            reset,
    keccak_padder_if.slave  p
);
`ifdef PADDER_SHA3_DOMAIN_EN
    localparam logic [7:0] PAD_BYTE = 8'h06;
`else
    localparam logic [7:0] PAD_BYTE = 8'h01;
`endif
    localparam logic [3:0] LAST_SLOT = 4'(RATE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, FILL, PAD, FULL} state_t;

    state_t       state, state_d;
    logic [3:0]   cnt, cnt_d;
    logic         last_q, last_d;
    logic         wr_en, clr, take;
    logic [W-1:0] wr_data, tail;
    logic [5:0]   sh;
    logic [W-1:0] blk [RATE_WORDS];

    assign p.in_ready  = reset & ((state == IDLE) | (state == FILL));
    assign p.out_valid = (state == FULL);
    assign p.out_last  = last_q;
    assign take        = p.in_valid & p.in_ready;

    // Keep byte_num MSB bytes, drop the pad byte right after them.
    assign sh   = {p.byte_num, 3'b000};
    assign tail = (p.in & ~({W{1'b1}} >> sh))
                | ({{(W-8){1'b0}}, PAD_BYTE} << (6'd56 - sh));

    always_comb begin
        p.out = '0;
        for (int i = 0; i < RATE_WORDS; i++)
            p.out[W*(RATE_WORDS-i)-1 -: W] = blk[i];
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        last_d  = last_q;
        wr_en   = 1'b0;
        wr_data = '0;
        clr     = 1'b0;
        unique case (state)
            IDLE, FILL: begin
                if (take) begin
                    wr_en   = 1'b1;
                    cnt_d   = cnt + 4'd1;
                    state_d = FILL;
                    if (p.is_last) begin
                        wr_data = tail;
                        state_d = PAD;
                        if (cnt == LAST_SLOT) begin
                            wr_data = {tail[W-1:8], tail[7:0] | 8'h80};
                            state_d = FULL;
                            last_d  = 1'b1;
                        end
                    end else begin
                        wr_data = p.in;
                        if (cnt == LAST_SLOT)
                            state_d = FULL;
                    end
                end
            end
            PAD: begin
                wr_en = 1'b1;
                cnt_d = cnt + 4'd1;
                if (cnt == LAST_SLOT) begin
                    wr_data = {{(W-8){1'b0}}, 8'h80};
                    state_d = FULL;
                    last_d  = 1'b1;
                end
            end
            FULL: begin
                if (p.f_ack) begin
                    clr     = 1'b1;
                    cnt_d   = '0;
                    last_d  = 1'b0;
                    state_d = FILL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            last_q <= 1'b0;
            for (int i = 0; i < RATE_WORDS; i++)
                blk[i] <= '0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            last_q <= last_d;
            for (int i = 0; i < RATE_WORDS; i++) begin
                if (clr)
                    blk[i] <= '0;
                else if (wr_en && cnt == 4'(i))
                    blk[i] <= wr_data;
            end
        end
    end
endmodule

// File: tb/tb_keccak_padder.sv
// Bench for keccak_padder: directed vector table, corner sequences and
// random messages checked against a byte-level pad10*1 model.
module tb_keccak_padder;
`ifdef PADDER_SHA3_DOMAIN_EN
    localparam logic [7:0] PADB = 8'h06;
`else
    localparam logic [7:0] PADB = 8'h01;
`endif

    typedef logic [63:0] wvec_t [9];
    typedef struct {
        int          nfull;
        bit          tail;
        int          bn;
        logic [63:0] tailw;
        logic [63:0] w0;
        logic [63:0] w8;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    keccak_padder_if bus ();
    keccak_padder dut (.clk(clk), .reset(reset), .p(bus));

    task automatic chk(input string name, input logic [575:0] got,
                       input logic [575:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, got, exp);
        end
    endtask

    // Block as a byte string: message bytes, pad byte, final 0x80.
    function automatic logic [575:0] model(input wvec_t w, input int nfull,
                                           input bit tail, input int bn);
        logic [7:0]   b [72];
        logic [575:0] r;
        foreach (b[k]) b[k] = 8'h00;
        for (int i = 0; i < nfull; i++)
            for (int j = 0; j < 8; j++)
                b[i*8+j] = w[i][63-8*j -: 8];
        if (tail) begin
            for (int j = 0; j < bn; j++)
                b[nfull*8+j] = w[nfull][63-8*j -: 8];
            b[nfull*8+bn] = b[nfull*8+bn] | PADB;
            b[71] = b[71] | 8'h80;
        end
        r = '0;
        for (int k = 0; k < 72; k++)
            r[575-8*k -: 8] = b[k];
        return r;
    endfunction

    task automatic put(input logic [63:0] w, input bit last,
                       input logic [2:0] bn, input bit noise);
        int n;
        bus.in       = w;
        bus.is_last  = last;
        bus.byte_num = bn;
        bus.in_valid = 1'b1;
        bus.f_ack    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL put_timeout: in_ready got 0, want 1");
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.is_last  = 1'b0;
        bus.f_ack    = 1'b0;
    endtask

    task automatic run_block(input string name, input wvec_t w,
                             input int nfull, input bit tail, input int bn,
                             input int hold, input bit noise,
                             output logic [575:0] blk);
        int n;
        for (int i = 0; i < nfull; i++)
            put(w[i], 1'b0, noise ? 3'($urandom_range(0, 7)) : 3'd0, noise);
        if (tail)
            put(w[nfull], 1'b1, 3'(bn), noise);
        n = 0;
        while (!bus.out_valid && n < 30) begin
            @(posedge clk); #1;
            n++;
            if (!bus.out_valid)
                chk({name, "_pad_ready"}, bus.in_ready, 0);
        end
        chk({name, "_pad_cycles"}, n, tail ? 8 - nfull : 0);
        chk({name, "_valid"}, bus.out_valid, 1);
        chk({name, "_last"}, bus.out_last, tail);
        chk({name, "_block"}, bus.out, model(w, nfull, tail, bn));
        chk({name, "_full_ready"}, bus.in_ready, 0);
        blk = bus.out;
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = 1'b1;
            bus.in       = {$urandom, $urandom};
            @(posedge clk); #1;
            chk({name, "_hold_out"}, bus.out, blk);
            chk({name, "_hold_ready"}, bus.in_ready, 0);
            chk({name, "_hold_valid"}, bus.out_valid, 1);
        end
        bus.in_valid = 1'b0;
        bus.f_ack    = 1'b1;
        @(posedge clk); #1;
        bus.f_ack = 1'b0;
        chk({name, "_ack_valid"}, bus.out_valid, 0);
        chk({name, "_ack_ready"}, bus.in_ready, 1);
        chk({name, "_ack_last"}, bus.out_last, 0);
        chk({name, "_ack_clear"}, bus.out, '0);
    endtask

    initial begin
        vec_t         tbl [5];
        wvec_t        w;
        logic [575:0] blk;

        tbl[0] = '{0, 1'b1, 0, 64'h0, {PADB, 56'h0}, 64'h80};
        tbl[1] = '{0, 1'b1, 3, 64'hAABBCC0000000000,
                   {24'hAABBCC, PADB, 32'h0}, 64'h80};
        tbl[2] = '{9, 1'b0, 0, 64'h0, 64'h1111111111111111,
                   64'h9999999999999999};
        tbl[3] = '{8, 1'b1, 7, 64'h0102030405060700, 64'h1111111111111111,
                   {56'h01020304050607, PADB | 8'h80}};
        tbl[4] = '{4, 1'b1, 0, 64'h0, 64'h1111111111111111, 64'h80};

        bus.in = '0; bus.in_valid = 1'b0; bus.is_last = 1'b0;
        bus.byte_num = '0; bus.f_ack = 1'b0;
        reset = 1'b0;
        #2;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_last", bus.out_last, 0);
        chk("rst_out", bus.out, '0);
        chk("rst_ready", bus.in_ready, 0);
        #10 reset = 1'b1;
        #1 chk("rel_ready", bus.in_ready, 1);
        @(posedge clk); #1;

        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < 9; i++) w[i] = {16{4'(i + 1)}};
            if (tbl[t].tail) w[tbl[t].nfull] = tbl[t].tailw;
            run_block($sformatf("vec%0d", t), w, tbl[t].nfull, tbl[t].tail,
                      tbl[t].bn, (t == 2) ? 5 : 0, 1'b0, blk);
            chk($sformatf("vec%0d_w0", t), blk[575:512], tbl[t].w0);
            chk($sformatf("vec%0d_w8", t), blk[63:0], tbl[t].w8);
        end

        for (int i = 0; i < 4; i++) put({16{4'(i + 1)}}, 1'b0, 3'd0, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("midrst_valid", bus.out_valid, 0);
        chk("midrst_out", bus.out, '0);
        chk("midrst_last", bus.out_last, 0);
        chk("midrst_ready", bus.in_ready, 0);
        #2 reset = 1'b1;
        @(posedge clk); #1;
        w[0] = '0;
        run_block("after_rst", w, 0, 1'b1, 0, 0, 1'b0, blk);
        chk("after_rst_w0", blk[575:512], tbl[0].w0);
        chk("after_rst_w8", blk[63:0], tbl[0].w8);

        for (int r = 0; r < 25; r++) begin
            int nb;
            int nf;
            nb = $urandom_range(0, 1);
            for (int b = 0; b < nb; b++) begin
                for (int i = 0; i < 9; i++) w[i] = {$urandom, $urandom};
                run_block($sformatf("rnd%0d_full", r), w, 9, 1'b0, 0,
                          $urandom_range(0, 2), 1'b1, blk);
            end
            for (int i = 0; i < 9; i++) w[i] = {$urandom, $urandom};
            nf = $urandom_range(0, 8);
            run_block($sformatf("rnd%0d_tail", r), w, nf, 1'b1,
                      $urandom_range(0, 7), $urandom_range(0, 2), 1'b1, blk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/keccak_padder.md
Name: keccak_padder

Overview:
- Input-side producer for the Keccak permutation datapath: collects 64-bit message words and applies pad10*1 padding.
- Presents full 576-bit rate blocks (Keccak-512, r = 9 words) to the permutation controller and holds each block until acknowledged.
- It is the writer end of the block-state interface that the round logic consumes.

Parameters:
- W, 64, word width in bits (fixed; lane size)
- RATE_WORDS, 9, words per rate block (out width = W*RATE_WORDS = 576)

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- in  input  64  message word; first message byte in in[63:56]
- in_valid  input  1  word present on `in`
- in_ready  output  1  padder can accept a word this cycle
- is_last  input  1  qualifies `in` as the final (partial) word of the message
- byte_num  input  3  valid data bytes in the is_last word (0..7), MSB-aligned
- out  output  576  padded block; word 0 in out[575:512], word 8 in out[63:0]
- out_valid  output  1  `out` holds a complete block
- out_last  output  1  current block is the final block of the message
- f_ack  input  1  consumer takes the block (sampled only while out_valid)

Behaviour:
- Reset (async, reset=0): state=IDLE, word count=0, out=0, out_valid=0, out_last=0, in_ready=0 while reset is asserted, 1 in the first cycle after release.
- A transfer occurs when in_valid & in_ready at a rising clk. Data is written into word slot `cnt` (0..8) and cnt increments.
- States:
  - IDLE/FILL: in_ready=1.
  - PAD: in_ready=0; appends one zero word per cycle.
  - FULL: in_ready=0, out_valid=1.
- FILL, non-last transfer: the word is stored. If cnt was 8, go to FULL with out_last=0.
- FILL, is_last transfer: the slot gets the byte_num MSB bytes of `in`, byte 0x01 at byte index byte_num, and zeros below. If cnt was 8, go to FULL with out_last=1. Otherwise go to PAD.
- PAD: writes zero words into the remaining slots, one per cycle. After writing slot 8, go to FULL with out_last=1.
- Final-byte rule: on entry to FULL with out_last=1, out[7:0] |= 0x80. If 0x01 landed in that byte, it becomes 0x81.
- A full last word is sent as a non-last word followed by is_last with byte_num=0. The padding therefore always fits in the current block; no extra block is ever generated.
- out_valid rises in the cycle after the 9th word is written (non-last) or after the last PAD write. For a 9-word message, the last word goes to slot 8, so out_valid follows that write directly.
- FULL + f_ack: out_valid=0 and cnt=0 next cycle. If out_last was 1, out_last clears. The state returns to FILL (in_ready=1 next cycle) and the buffer is zeroed.
- f_ack while out_valid=0 is ignored. out is stable while out_valid=1.
- in_valid while in_ready=0: ignored, no transfer.
- byte_num is ignored unless is_last.
- is_last with byte_num=0 at cnt=0 yields a block of 0x01, zeros, and final byte 0x80.
- Reset asserted mid-block or in FULL: everything is discarded and all outputs return to their reset values immediately.

Optional Feature:
- Macro PADDER_SHA3_DOMAIN_EN.
- Defined: the first padding byte is 0x06 (SHA-3 domain separation) instead of 0x01. The coincident final byte becomes 0x86.
- Undefined: Keccak pad byte 0x01, as specified above.

Test Plan:
- Empty message: after reset, is_last=1, byte_num=0, cnt=0. Expect 8 PAD cycles, then out_valid=1, out_last=1, out[575:568]=0x01, out[7:0]=0x80, all other bits 0.
- 3-byte message: in=0xAABBCC0000000000, is_last=1, byte_num=3. Expect out[575:512]=0xAABBCC0100000000, out[7:0]=0x80, out_last=1.
- Exact 9-word block: nine non-last words 0x1111..1 through 0x9999..9 on back-to-back cycles. Expect out_valid in the cycle after word 9, out_last=0, and in_ready=0 until f_ack.
- Coincident pad byte: 8 full words, then is_last with byte_num=7 and in=0x0102030405060700. Expect out[63:0]=0x0102030405060781, with no PAD cycles.
- Back-pressure and ack: hold f_ack=0 for 5 cycles in FULL. Expect out stable and in_ready=0. Pulse f_ack; expect out_valid=0 and in_ready=1 next cycle, with a new block starting from slot 0.
- Reset mid-block: assert reset low after 4 words. Expect out_valid=0 and out=0 asynchronously. A subsequent empty message must produce the same block as the empty-message test.
- With PADDER_SHA3_DOMAIN_EN defined: repeating the empty-message case gives out[575:568]=0x06, and the coincident case gives out[7:0]=0x86.
